// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side signal bundle for mem_arbiter.
// slave: arbiter view (req/we/addr/wdata/mem_rdata in; gnt/rvalid/rdata/mem_* out).
interface mem_arbiter_if #(
  parameter int NCORES = 4
);
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    we;
  logic [16*NCORES-1:0] addr;
  logic [16*NCORES-1:0] wdata;
  logic [NCORES-1:0]    gnt;
  logic [NCORES-1:0]    rvalid;
  logic [15:0]          rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [15:0]          mem_addr;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NCORES requesters.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int NCORES  = 4,
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     cur_id;
  logic [NCORES-1:0] gnt_q;
  logic [NCORES-1:0] elig;
  logic              en_q;
  logic              we_q;
  logic [15:0]       addr_q;
  logic [15:0]       wdata_q;
  logic [MEM_LAT-1:0] pv;
  logic [PW-1:0]     pid [MEM_LAT];
  logic              found;
  logic [PW-1:0]     win;
  int                idx;

  // A core granted this cycle still shows req; mask it.
  assign elig = bus.req & ~gnt_q;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NCORES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cur_id  <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pv      <= '0;
      for (int s = 0; s < MEM_LAT; s++) pid[s] <= '0;
    end else begin
      en_q <= found;
      if (found) begin
        gnt_q   <= NCORES'(1) << win;
        we_q    <= bus.we[win];
        addr_q  <= bus.addr[16*int'(win) +: 16];
        wdata_q <= bus.wdata[16*int'(win) +: 16];
        cur_id  <= win;
        ptr     <= (int'(win) == NCORES-1) ? '0 : win + PW'(1);
      end else begin
        gnt_q <= '0;
        we_q  <= 1'b0;
      end
      // Read-return pipe: stage 0 loads during the mem_en cycle.
      for (int s = MEM_LAT-1; s > 0; s--) begin
        pv[s]  <= pv[s-1];
        pid[s] <= pid[s-1];
      end
      pv[0]  <= en_q & ~we_q;
      pid[0] <= cur_id;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.rvalid    = pv[MEM_LAT-1] ?
                         (NCORES'(1) << pid[MEM_LAT-1]) : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-MEM_LAT memory model.
// Directed scenarios; monitor pops expected grants/returns.
module tb_mem_arbiter;
  localparam int NC  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NCORES(NC)) bus ();

  mem_arbiter #(.NCORES(NC), .MEM_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NC-1:0] g;
    logic          we;
    logic [15:0]   a;
    logic [15:0]   d;
  } gexp_t;

  typedef struct {
    logic [NC-1:0] g;
    logic [15:0]   d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    lat_q[$];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [NC-1:0] drop = '0;
  logic [NC-1:0] keep = '0;
  logic [NC-1:0] prev_gnt = '0;

  // Memory model: contents {a[7:0], ~a[7:0]}, 0x0042 holds 0xBEEF.
  logic [15:0] mem [512];
  logic [15:0] mpipe [LAT];
  assign bus.mem_rdata = mpipe[LAT-1];

  initial begin
    for (int i = 0; i < 512; i++)
      mem[i] = {i[7:0], ~i[7:0]};
    mem[9'h042] = 16'hBEEF;
  end

  always @(posedge clk) begin
    for (int s = LAT-1; s > 0; s--) mpipe[s] <= mpipe[s-1];
    mpipe[0] <= (bus.mem_en && !bus.mem_we) ?
                mem[bus.mem_addr[8:0]] : 16'h0000;
    if (bus.mem_en && bus.mem_we)
      mem[bus.mem_addr[8:0]] = bus.mem_wdata;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, sampled away from the active edge.
  always @(negedge clk) begin
    cyc++;
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    chk("rvalid_onehot0", 32'($onehot0(bus.rvalid)), 32'd1);
    chk("en_vs_gnt", 32'(bus.mem_en), 32'(bus.gnt != '0));
    chk("no_regrant", 32'(bus.gnt & prev_gnt), 32'd0);
    prev_gnt = bus.gnt;
    if (bus.gnt != '0) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
      end else begin
        gexp_t e;
        e = gq.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(e.g));
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.a));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.d));
      end
    end
    if (bus.rvalid != '0) begin
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        chk("rvalid", 32'(bus.rvalid), 32'(r.g));
        chk("rdata", 32'(bus.rdata), 32'(r.d));
      end
      if (lat_q.size() == 0) begin
        chk("rvalid_no_issue", 32'd1, 32'd0);
      end else begin
        int t;
        t = lat_q.pop_front();
        chk("read_latency", 32'(cyc - t), 32'(LAT));
      end
    end
    if (rst) lat_q.delete();
    if (bus.mem_en && !bus.mem_we) lat_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.req = bus.req & ~drop;
    drop    = bus.gnt & ~keep;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    drop      = '0;
    keep      = '0;
    step();
    step();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
  endtask

  task automatic set_core(input int i, input logic w,
                          input logic [15:0] a,
                          input logic [15:0] d);
    bus.we[i]           = w;
    bus.addr[16*i +: 16]  = a;
    bus.wdata[16*i +: 16] = d;
    bus.req[i]          = 1'b1;
  endtask

  task automatic pushg(input logic [NC-1:0] g, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    gexp_t e;
    e.g = g; e.we = w; e.a = a; e.d = d;
    gq.push_back(e);
  endtask

  task automatic pushr(input logic [NC-1:0] g, input logic [15:0] d);
    rexp_t r;
    r.g = g; r.d = d;
    rq.push_back(r);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < 30) begin
      step();
      n++;
    end
    step();
    step();
    chk({nm, "_gq_left"}, 32'(gq.size()), 32'd0);
    chk({nm, "_rq_left"}, 32'(rq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

    // Idle after reset.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_en", 32'(bus.mem_en), 32'd0);
      chk("idle_gnt", 32'(bus.gnt), 32'd0);
      chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
      chk("idle_addr", 32'(bus.mem_addr), 32'd0);
    end

    // Single read, exact timing.
    do_reset();
    set_core(1, 1'b0, 16'h0042, 16'h0000);
    pushg(4'b0010, 1'b0, 16'h0042, 16'h0000);
    pushr(4'b0010, 16'hBEEF);
    step();
    chk("t1_gnt", 32'(bus.gnt), 32'h2);
    chk("t1_addr", 32'(bus.mem_addr), 32'h0042);
    step();
    chk("t1_rv_c2", 32'(bus.rvalid), 32'h0);
    step();
    chk("t1_rv_c3", 32'(bus.rvalid), 32'h2);
    chk("t1_rdata", 32'(bus.rdata), 32'hBEEF);
    step();
    chk("t1_rv_c4", 32'(bus.rvalid), 32'h0);
    drain("t1");

    // All four read at once.
    do_reset();
    for (int i = 0; i < NC; i++)
      set_core(i, 1'b0, 16'h0010 + 16'(i), 16'h0000);
    pushg(4'b0001, 1'b0, 16'h0010, 16'h0000);
    pushg(4'b0010, 1'b0, 16'h0011, 16'h0000);
    pushg(4'b0100, 1'b0, 16'h0012, 16'h0000);
    pushg(4'b1000, 1'b0, 16'h0013, 16'h0000);
    pushr(4'b0001, 16'h10EF);
    pushr(4'b0010, 16'h11EE);
    pushr(4'b0100, 16'h12ED);
    pushr(4'b1000, 16'h13EC);
    drain("t2");

    // Core 0 hogs, core 2 once.
    do_reset();
    keep = 4'b0001;
    set_core(0, 1'b0, 16'h0020, 16'h0000);
    set_core(2, 1'b0, 16'h0022, 16'h0000);
    pushg(4'b0001, 1'b0, 16'h0020, 16'h0000);
    pushg(4'b0100, 1'b0, 16'h0022, 16'h0000);
    pushg(4'b0001, 1'b0, 16'h0020, 16'h0000);
    pushg(4'b0001, 1'b0, 16'h0020, 16'h0000);
    pushr(4'b0001, 16'h20DF);
    pushr(4'b0100, 16'h22DD);
    pushr(4'b0001, 16'h20DF);
    pushr(4'b0001, 16'h20DF);
    for (int k = 0; k < 4; k++) step();
    chk("t3_c4_gnt", 32'(bus.gnt), 32'h0);
    step();
    chk("t3_c5_gnt", 32'(bus.gnt), 32'h1);
    keep = '0;
    drop = bus.gnt;
    drain("t3");

    // Write produces no return.
    do_reset();
    set_core(3, 1'b1, 16'h0100, 16'h1234);
    pushg(4'b1000, 1'b1, 16'h0100, 16'h1234);
    step();
    chk("t4_we", 32'(bus.mem_we), 32'd1);
    chk("t4_wdata", 32'(bus.mem_wdata), 32'h1234);
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      chk("t4_en_off", 32'(bus.mem_en), 32'd0);
      chk("t4_we_off", 32'(bus.mem_we), 32'd0);
      chk("t4_no_rv", 32'(bus.rvalid), 32'd0);
    end
    drain("t4");

    // Reset drops an in-flight read; re-arbitrate from 0.
    do_reset();
    set_core(2, 1'b0, 16'h0032, 16'h0000);
    pushg(4'b0100, 1'b0, 16'h0032, 16'h0000);
    step();
    rst = 1'b1;
    set_core(1, 1'b0, 16'h0031, 16'h0000);
    set_core(3, 1'b0, 16'h0033, 16'h0000);
    step();
    chk("t5_c2_en", 32'(bus.mem_en), 32'd0);
    chk("t5_c2_rv", 32'(bus.rvalid), 32'd0);
    step();
    chk("t5_c3_en", 32'(bus.mem_en), 32'd0);
    chk("t5_c3_rv", 32'(bus.rvalid), 32'd0);
    rst = 1'b0;
    pushg(4'b0010, 1'b0, 16'h0031, 16'h0000);
    pushg(4'b1000, 1'b0, 16'h0033, 16'h0000);
    pushr(4'b0010, 16'h31CE);
    pushr(4'b1000, 16'h33CC);
    step();
    chk("t5_c4_gnt", 32'(bus.gnt), 32'h2);
    chk("t5_c4_rv", 32'(bus.rvalid), 32'd0);
    step();
    chk("t5_c5_rv", 32'(bus.rvalid), 32'd0);
    drain("t5");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
